// File: rtl/player_life_ctrl.sv
// Player life FSM: collision level -> hits, lives, invincibility, blink, game over.
// Latency: every output is registered and reflects inputs one clk later. Backpressure: none, inputs sampled every clk.
module player_life_ctrl #(
   parameter int INIT_LIVES   = 3,
   parameter int MAX_LIVES    = 5,
   parameter int INVUL_FRAMES = 120,
   parameter int BLINK_FRAMES = 8,
   parameter int LIFE_W       = 3
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              frame_tick,
   input  logic              collision,
   input  logic              game_start,
   input  logic              extra_life,
   output logic [LIFE_W-1:0] lives,
   output logic              invincible,
   output logic              player_visible,
   output logic              hit_pulse,
   output logic              game_over
);

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      ALIVE     = 2'd1,
      INVUL     = 2'd2,
      GAME_OVER = 2'd3
   } state_t;

   localparam logic [LIFE_W-1:0] INIT_L   = LIFE_W'(INIT_LIVES);
   localparam logic [LIFE_W-1:0] MAX_L    = LIFE_W'(MAX_LIVES);
   localparam logic [LIFE_W-1:0] ONE_L    = LIFE_W'(1);
   localparam logic [7:0]        INVUL_LD = 8'(INVUL_FRAMES);
   localparam logic [7:0]        BLINK_LD = 8'(BLINK_FRAMES);

   state_t     state;
   logic [7:0] inv_cnt;
   logic [7:0] blink_cnt;

   function automatic logic [LIFE_W-1:0] inc_sat(input logic [LIFE_W-1:0] l);
      return (l >= MAX_L) ? MAX_L : l + ONE_L;
   endfunction

   always_ff @(posedge clk) begin
      if (rst) begin
         state          <= IDLE;
         lives          <= INIT_L;
         invincible     <= 1'b0;
         player_visible <= 1'b1;
         hit_pulse      <= 1'b0;
         game_over      <= 1'b0;
         inv_cnt        <= 8'd0;
         blink_cnt      <= 8'd0;
      end else begin
         hit_pulse <= 1'b0;
         if (game_start) begin
            state          <= ALIVE;
            lives          <= INIT_L;
            invincible     <= 1'b0;
            player_visible <= 1'b1;
            game_over      <= 1'b0;
            inv_cnt        <= 8'd0;
            blink_cnt      <= 8'd0;
         end else begin
            case (state)
               IDLE: begin
                  player_visible <= 1'b1;
               end

               ALIVE: begin
                  if (collision) begin
                     hit_pulse <= 1'b1;
                     // Last life goes straight to game over, no invincibility window.
                     if (lives <= ONE_L) begin
                        lives          <= '0;
                        state          <= GAME_OVER;
                        game_over      <= 1'b1;
                        invincible     <= 1'b0;
                        player_visible <= 1'b0;
                     end else begin
                        lives          <= lives - ONE_L;
                        state          <= INVUL;
                        invincible     <= 1'b1;
                        player_visible <= 1'b0;
                        inv_cnt        <= INVUL_LD;
                        blink_cnt      <= 8'd0;
                     end
                  end else if (extra_life) begin
                     lives <= inc_sat(lives);
                  end
               end

               INVUL: begin
                  if (extra_life) begin
                     lives <= inc_sat(lives);
                  end
                  if (frame_tick) begin
                     if (inv_cnt <= 8'd1) begin
                        state          <= ALIVE;
                        invincible     <= 1'b0;
                        player_visible <= 1'b1;
                        inv_cnt        <= 8'd0;
                        blink_cnt      <= 8'd0;
                     end else begin
                        inv_cnt <= inv_cnt - 8'd1;
                        // Toggle when this tick completes a full blink period.
                        if (blink_cnt >= BLINK_LD - 8'd1) begin
                           blink_cnt      <= 8'd0;
                           player_visible <= ~player_visible;
                        end else begin
                           blink_cnt <= blink_cnt + 8'd1;
                        end
                     end
                  end
               end

               GAME_OVER: begin
                  game_over      <= 1'b1;
                  player_visible <= 1'b0;
                  invincible     <= 1'b0;
                  lives          <= '0;
               end

               default: begin
                  state <= IDLE;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_player_life_ctrl.sv
// Scoreboard bench for player_life_ctrl: stimulus queues expected output snapshots and hits, a monitor pops and compares.
module tb_player_life_ctrl;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       frame_tick = 1'b0;
   logic       collision = 1'b0;
   logic       game_start = 1'b0;
   logic       extra_life = 1'b0;
   logic [2:0] lives;
   logic       invincible;
   logic       player_visible;
   logic       hit_pulse;
   logic       game_over;

   int total = 0;
   int bad = 0;
   int cyc = 0;

   typedef struct {
      int         due;
      logic [2:0] l;
      logic       inv;
      logic       vis;
      logic       hp;
      logic       go;
   } exp_t;

   exp_t sq[$];
   int   hq[$];
   exp_t me;
   int   mh;

   player_life_ctrl dut (
      .clk            (clk),
      .rst            (rst),
      .frame_tick     (frame_tick),
      .collision      (collision),
      .game_start     (game_start),
      .extra_life     (extra_life),
      .lives          (lives),
      .invincible     (invincible),
      .player_visible (player_visible),
      .hit_pulse      (hit_pulse),
      .game_over      (game_over)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Monitor: hit pulses consume the hit queue; due snapshots consume the status queue.
   always @(negedge clk) begin
      if (hit_pulse) begin
         total++;
         if (hq.size() == 0) begin
            bad++;
            $display("FAIL hit_q cyc=%0d: unexpected hit_pulse, lives=%0d", cyc, lives);
         end else begin
            mh = hq.pop_front();
            if (lives !== 3'(mh)) begin
               bad++;
               $display("FAIL hit_lives cyc=%0d: got lives=%0d want %0d", cyc, lives, mh);
            end
         end
      end
      while (sq.size() > 0 && sq[0].due <= cyc) begin
         me = sq.pop_front();
         total++;
         if (me.due != cyc) begin
            bad++;
            $display("FAIL status_late: due=%0d now=%0d", me.due, cyc);
         end else if ({lives, invincible, player_visible, hit_pulse, game_over} !==
                      {me.l, me.inv, me.vis, me.hp, me.go}) begin
            bad++;
            $display("FAIL status cyc=%0d: got lives=%0d inv=%b vis=%b hit=%b go=%b want lives=%0d inv=%b vis=%b hit=%b go=%b",
                     cyc, lives, invincible, player_visible, hit_pulse, game_over,
                     me.l, me.inv, me.vis, me.hp, me.go);
         end
      end
   end

   task automatic step(input logic r, input logic gs, input logic col, input logic el, input logic ft,
                       input int l, input logic inv, input logic vis, input logic hp, input logic go);
      exp_t e;
      @(negedge clk);
      rst        = r;
      game_start = gs;
      collision  = col;
      extra_life = el;
      frame_tick = ft;
      e.due = cyc + 1;
      e.l   = 3'(l);
      e.inv = inv;
      e.vis = vis;
      e.hp  = hp;
      e.go  = go;
      sq.push_back(e);
      if (hp) hq.push_back(l);
   endtask

   // 120 frame ticks through an invincibility window; sprite shows on odd 8-frame blocks.
   task automatic invul_run(input int l, input int col_frames);
      for (int i = 1; i <= 120; i++) begin
         if (i < 120)
            step(0, 0, (i <= col_frames), 0, 1, l, 1, ((i / 8) % 2) != 0, 0, 0);
         else
            step(0, 0, (i <= col_frames), 0, 1, l, 0, 1, 0, 0);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: run did not complete, cyc=%0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      step(1, 0, 0, 0, 0, 3, 0, 1, 0, 0);
      step(1, 0, 0, 0, 0, 3, 0, 1, 0, 0);
      step(0, 0, 1, 1, 1, 3, 0, 1, 0, 0);    // IDLE ignores collision/extra_life
      step(0, 1, 0, 0, 0, 3, 0, 1, 0, 0);
      step(0, 0, 0, 0, 0, 3, 0, 1, 0, 0);
      step(0, 0, 1, 0, 1, 2, 1, 0, 1, 0);    // hit; frame_tick in entry cycle not counted
      invul_run(2, 50);
      step(0, 0, 0, 0, 0, 2, 0, 1, 0, 0);
      step(0, 0, 1, 0, 0, 1, 1, 0, 1, 0);
      invul_run(1, 120);                     // collision held through the whole window
      step(0, 0, 1, 0, 0, 0, 0, 0, 1, 1);    // held collision hits right after INVUL
      step(0, 0, 1, 1, 1, 0, 0, 0, 0, 1);
      step(0, 0, 0, 1, 0, 0, 0, 0, 0, 1);
      step(0, 1, 0, 0, 0, 3, 0, 1, 0, 0);
      step(0, 0, 0, 1, 0, 4, 0, 1, 0, 0);
      step(0, 0, 0, 1, 0, 5, 0, 1, 0, 0);
      step(0, 0, 0, 1, 0, 5, 0, 1, 0, 0);
      step(0, 0, 0, 1, 0, 5, 0, 1, 0, 0);
      step(0, 0, 1, 1, 0, 4, 1, 0, 1, 0);    // collision beats extra_life
      step(0, 0, 0, 1, 0, 5, 1, 0, 0, 0);
      step(0, 0, 1, 1, 1, 5, 1, 0, 0, 0);
      step(1, 0, 1, 0, 1, 3, 0, 1, 0, 0);    // reset mid-INVUL
      step(0, 0, 1, 0, 0, 3, 0, 1, 0, 0);
      step(0, 1, 0, 0, 0, 3, 0, 1, 0, 0);
      step(0, 0, 0, 1, 0, 4, 0, 1, 0, 0);
      step(0, 1, 1, 1, 0, 3, 0, 1, 0, 0);    // game_start beats collision
      step(0, 0, 0, 0, 1, 3, 0, 1, 0, 0);
      step(0, 0, 1, 0, 0, 2, 1, 0, 1, 0);
      step(0, 0, 0, 0, 1, 2, 1, 0, 0, 0);
      step(1, 1, 0, 0, 0, 3, 0, 1, 0, 0);    // rst beats game_start
      step(0, 0, 1, 0, 0, 3, 0, 1, 0, 0);
      step(0, 0, 0, 0, 0, 3, 0, 1, 0, 0);
      step(0, 0, 0, 0, 0, 3, 0, 1, 0, 0);
      @(negedge clk);
      @(negedge clk);
      total++;
      if (sq.size() != 0) begin
         bad++;
         $display("FAIL status_drain: %0d entries left, want 0", sq.size());
      end
      total++;
      if (hq.size() != 0) begin
         bad++;
         $display("FAIL hit_drain: %0d expected hits never seen, want 0", hq.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
